// File: rtl/rv32_led_mmio_if.sv
// Data-bus bundle between the priRV32 load/store port (master) and a memory-mapped responder (slave).
interface rv32_led_mmio_if;
  logic        valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output valid, we, addr, wdata, wstrb,
    input  ready, rdata, err
  );

  modport slave (
    input  valid, we, addr, wdata, wstrb,
    output ready, rdata, err
  );
endinterface

// File: rtl/rv32_led_mmio.sv
// Memory-mapped LED peripheral: LED register with set/clear/toggle aliases, prescaled blink timer,
// and a sticky maskable tick interrupt, answering word accesses in a 32-byte window.
module rv32_led_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned PRESCALE_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  rv32_led_mmio_if.slave   bus,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

  localparam logic [2:0] R_LED_OUT = 3'd0;
  localparam logic [2:0] R_LED_SET = 3'd1;
  localparam logic [2:0] R_LED_CLR = 3'd2;
  localparam logic [2:0] R_LED_TGL = 3'd3;
  localparam logic [2:0] R_MASK    = 3'd4;
  localparam logic [2:0] R_PERIOD  = 3'd5;
  localparam logic [2:0] R_STATUS  = 3'd6;
  localparam logic [2:0] R_CTRL    = 3'd7;

  state_e                state_q, state_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic [LED_W-1:0]      mask_q, mask_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  tick_q, tick_d;
  logic                  blink_en_q, blink_en_d;
  logic                  irq_en_q, irq_en_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  hit;
  logic                  wr;
  logic                  rd;
  logic [2:0]            reg_idx;
  logic [31:0]           bmask;
  logic [31:0]           wd_m;
  logic [LED_W-1:0]      led_bm;
  logic [LED_W-1:0]      led_wd;
  logic                  tick_evt;
  logic [LED_W-1:0]      led_t;
  logic [31:0]           rd_val;
  logic                  unused_wdata;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign accept  = (state_q == S_IDLE) && bus.valid;
  assign hit     = (bus.addr[31:5] == BASE_ADDR[31:5]) && (bus.addr[1:0] == 2'b00);
  assign wr      = accept && hit && bus.we;
  assign rd      = accept && hit && !bus.we;
  assign reg_idx = bus.addr[4:2];

  assign bmask   = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign wd_m    = bus.wdata & bmask;
  assign led_bm  = bmask[LED_W-1:0];
  assign led_wd  = wd_m[LED_W-1:0];
  assign unused_wdata = ^wd_m;

  // Blink toggle lands before any bus op so aliases see the toggled value.
  assign tick_evt = blink_en_q && (period_q != '0) && (cnt_q == period_q);
  assign led_t    = tick_evt ? (led_q ^ mask_q) : led_q;

  // ---------------------------------------------------------------------------
  // Handshake FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.valid) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state_q == S_ACK);
    bus.rdata = rdata_q;
    bus.err   = err_q;
  end

  // ---------------------------------------------------------------------------
  // Register file and blink counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    unique case (reg_idx)
      R_LED_OUT: rd_val = 32'(led_q);
      R_MASK:    rd_val = 32'(mask_q);
      R_PERIOD:  rd_val = 32'(period_q);
      R_STATUS:  rd_val = {31'b0, tick_q};
      R_CTRL:    rd_val = {30'b0, irq_en_q, blink_en_q};
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    led_d      = led_t;
    mask_d     = mask_q;
    period_d   = period_q;
    tick_d     = tick_q;
    blink_en_d = blink_en_q;
    irq_en_d   = irq_en_q;

    if (!blink_en_q || (period_q == '0) || tick_evt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end

    if (wr) begin
      unique case (reg_idx)
        R_LED_OUT: led_d = (led_t & ~led_bm) | led_wd;
        R_LED_SET: led_d = led_t | led_wd;
        R_LED_CLR: led_d = led_t & ~led_wd;
        R_LED_TGL: led_d = led_t ^ led_wd;
        R_MASK:    mask_d = (mask_q & ~led_bm) | led_wd;
        R_PERIOD: begin
          period_d = (period_q & ~bmask[PRESCALE_W-1:0]) | wd_m[PRESCALE_W-1:0];
          cnt_d    = '0;
        end
        R_STATUS:  if (wd_m[0]) tick_d = 1'b0;
        R_CTRL: begin
          if (bus.wstrb[0]) begin
            blink_en_d = bus.wdata[0];
            irq_en_d   = bus.wdata[1];
          end
          cnt_d = '0;
        end
        default: ;
      endcase
    end

    // A new tick wins over a simultaneous W1C.
    if (tick_evt) tick_d = 1'b1;

    rdata_d = rd ? rd_val : 32'b0;
    err_d   = accept && !hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      mask_q     <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      blink_en_q <= 1'b0;
      irq_en_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      led_q      <= led_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      blink_en_q <= blink_en_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign led = led_q;
  assign irq = tick_q & irq_en_q;

endmodule

// File: tb/tb_rv32_led_mmio.sv
// Directed bench for rv32_led_mmio: stimulus pushes expected responses, a monitor pops and compares on bus_ready.
module tb_rv32_led_mmio;

  logic       clk;
  logic       reset;
  logic [7:0] led;
  logic       irq;

  rv32_led_mmio_if bus_if ();

  rv32_led_mmio #(
    .BASE_ADDR (32'h1000_0000),
    .LED_W     (8),
    .PRESCALE_W(24)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave),
    .led  (led),
    .irq  (irq)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  led;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic prev_ready = 1'b0;

  localparam logic [31:0] BASE = 32'h1000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample one time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (bus_if.ready === 1'b1) begin
      check("ready_single_cycle", {31'b0, prev_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rdata", bus_if.rdata, e.rdata);
        check("err",   {31'b0, bus_if.err}, {31'b0, e.err});
        check("led",   {24'b0, led}, {24'b0, e.led});
      end
    end
    prev_ready = bus_if.ready;
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic [7:0] exp_led);
    exp_t e;
    @(negedge clk);
    bus_if.valid = 1'b1;
    bus_if.we    = we;
    bus_if.addr  = addr;
    bus_if.wdata = wdata;
    bus_if.wstrb = wstrb;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.led   = exp_led;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus_if.valid = 1'b0;
    bus_if.we    = 1'b0;
    @(posedge clk);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s, input logic [7:0] exp_led);
    access(1'b1, BASE | 32'(off), d, s, 32'd0, 1'b0, exp_led);
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp_rdata, input logic [7:0] exp_led);
    access(1'b0, BASE | 32'(off), 32'd0, 4'h0, exp_rdata, 1'b0, exp_led);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus_if.valid = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    bus_if.wstrb = '0;

    // Reset state
    #22;
    check("rst_ready", {31'b0, bus_if.ready}, 32'd0);
    check("rst_rdata", bus_if.rdata, 32'd0);
    check("rst_err",   {31'b0, bus_if.err}, 32'd0);
    check("rst_led",   {24'b0, led}, 32'd0);
    check("rst_irq",   {31'b0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic write/read
    wr(5'h00, 32'h0000_00A5, 4'hF, 8'hA5);
    rd(5'h00, 32'h0000_00A5, 8'hA5);

    // Aliases and strobes
    wr(5'h00, 32'h0000_00F0, 4'hF, 8'hF0);
    wr(5'h04, 32'h0000_000F, 4'hF, 8'hFF);
    wr(5'h08, 32'h0000_0081, 4'hF, 8'h7E);
    wr(5'h0C, 32'h0000_00FF, 4'hF, 8'h81);
    wr(5'h00, 32'h0000_0012, 4'h0, 8'h81);
    wr(5'h04, 32'h0000_00FF, 4'h0, 8'h81);
    wr(5'h00, 32'h0000_3300, 4'h2, 8'h81);
    rd(5'h04, 32'd0, 8'h81);

    // Decode errors
    access(1'b0, 32'h1000_0002, 32'd0, 4'h0, 32'd0, 1'b1, 8'h81);
    access(1'b1, 32'h1000_0020, 32'd0, 4'hF, 32'd0, 1'b1, 8'h81);
    access(1'b1, 32'h2000_0000, 32'd0, 4'hF, 32'd0, 1'b1, 8'h81);
    rd(5'h00, 32'h0000_0081, 8'h81);

    // Blink and irq: ticks land 4, 8, 12, 16 cycles after the CTRL write edge E
    wr(5'h00, 32'd0, 4'hF, 8'h00);
    wr(5'h10, 32'h0000_0001, 4'hF, 8'h00);
    wr(5'h14, 32'h0000_0003, 4'hF, 8'h00);
    rd(5'h14, 32'h0000_0003, 8'h00);
    wr(5'h1C, 32'h0000_0003, 4'hF, 8'h00);       // returns at E+1
    #1;
    check("blink_e1_led", {24'b0, led}, 32'h00);
    check("blink_e1_irq", {31'b0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("blink_e3_led", {24'b0, led}, 32'h00);
    @(posedge clk);
    #1;
    check("blink_e4_led", {24'b0, led}, 32'h01);
    check("blink_e4_irq", {31'b0, irq}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("blink_e8_led", {24'b0, led}, 32'h00);
    wr(5'h18, 32'h0000_0001, 4'hF, 8'h00);       // commits at E+9, returns at E+10
    #1;
    check("w1c_idle_irq", {31'b0, irq}, 32'd0);
    @(posedge clk);                                // E+11
    wr(5'h18, 32'h0000_0001, 4'hF, 8'h01);       // commits at tick E+12
    #1;
    check("w1c_tick_irq", {31'b0, irq}, 32'd1);
    repeat (2) @(posedge clk);                     // E+15
    wr(5'h0C, 32'h0000_0001, 4'hF, 8'h01);       // TGL collides with tick E+16
    #1;
    check("collide_irq", {31'b0, irq}, 32'd1);

    // Reset mid-access: write LED_OUT=0x5A, then reset during ACK
    begin
      exp_t e;
      @(negedge clk);
      bus_if.valid = 1'b1;
      bus_if.we    = 1'b1;
      bus_if.addr  = BASE;
      bus_if.wdata = 32'h0000_005A;
      bus_if.wstrb = 4'hF;
      e.rdata = 32'd0;
      e.err   = 1'b0;
      e.led   = 8'h5A;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
      check("pre_reset_irq", {31'b0, irq}, 32'd1);
      reset = 1'b1;
      #1;
      check("async_rst_led",   {24'b0, led}, 32'd0);
      check("async_rst_ready", {31'b0, bus_if.ready}, 32'd0);
      check("async_rst_irq",   {31'b0, irq}, 32'd0);
      check("async_rst_rdata", bus_if.rdata, 32'd0);
      @(negedge clk);
      bus_if.valid = 1'b0;
      bus_if.we    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
    end
    rd(5'h00, 32'd0, 8'h00);
    rd(5'h1C, 32'd0, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_irq", {31'b0, irq}, 32'd0);
    check("post_reset_led", {24'b0, led}, 32'd0);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
